// File: rtl/tohost_monitor.sv
// End-of-test monitor for tohost CSR writes from NUM_CH channels.
// It captures per-channel completion codes, enforces a run timeout and holds a sticky verdict.
module tohost_monitor #(
    parameter int NUM_CH         = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_WIDTH      = 32,
    parameter bit STOP_ON_FAIL   = 1'b0,
    localparam int FCH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH-1:0]            csr_we,
    input  logic [NUM_CH*DATA_WIDTH-1:0] csr_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timed_out,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [FCH_W-1:0]             fail_ch,
    output logic [DATA_WIDTH-2:0]        fail_code,
    output logic [CNT_WIDTH-1:0]         cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [NUM_CH-1:0]     r_mask;
    logic [NUM_CH-1:0]     r_ch_done;
    logic                  r_fail_valid;
    logic [FCH_W-1:0]      r_fail_ch;
    logic [DATA_WIDTH-2:0] r_fail_code;
    logic [CNT_WIDTH-1:0]  r_cycles;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timed_out;

    logic [NUM_CH-1:0]     w_cmpl;
    logic                  w_new_fail;
    logic [FCH_W-1:0]      w_new_ch;
    logic [DATA_WIDTH-2:0] w_new_code;
    logic [NUM_CH-1:0]     w_ch_done_nxt;
    logic                  w_fail_valid_nxt;
    logic                  w_take_fail;
    logic                  w_finish;

    // Scan high-to-low so the lowest failing channel completing this cycle wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_cmpl     = '0;
        w_new_fail = 1'b0;
        w_new_ch   = '0;
        w_new_code = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cmpl[i] = (r_state == S_RUN) && csr_we[i] && csr_wdata[i*DATA_WIDTH]
                        && r_mask[i] && !r_ch_done[i];
            if (w_cmpl[i] && (csr_wdata[i*DATA_WIDTH+1 +: DATA_WIDTH-1] != '0)) begin
                w_new_fail = 1'b1;
                w_new_ch   = FCH_W'(i);
                w_new_code = csr_wdata[i*DATA_WIDTH+1 +: DATA_WIDTH-1];
            end
        end
    end

    assign w_ch_done_nxt    = r_ch_done | w_cmpl;
    assign w_fail_valid_nxt = r_fail_valid | w_new_fail;
    assign w_take_fail      = w_new_fail && (!r_fail_valid || (w_new_ch < r_fail_ch));
    assign w_finish         = (&(w_ch_done_nxt | ~r_mask)) || (STOP_ON_FAIL && w_new_fail);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_ch_done    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_ch    <= '0;
            r_fail_code  <= '0;
            r_cycles     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cycles     <= r_cycles + CNT_WIDTH'(1);
                    r_ch_done    <= w_ch_done_nxt;
                    r_fail_valid <= w_fail_valid_nxt;
                    if (w_take_fail) begin
                        r_fail_ch   <= w_new_ch;
                        r_fail_code <= w_new_code;
                    end
                    // A completion on the last allowed cycle beats the timeout.
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_fail_valid_nxt;
                    end else if (r_cycles == LAST_CNT) begin
                        r_state     <= S_TIMEOUT;
                        r_busy      <= 1'b0;
                        r_timed_out <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_mask       <= ch_mask;
                        r_ch_done    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_ch    <= '0;
                        r_fail_code  <= '0;
                        r_cycles     <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_timed_out  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timed_out = r_timed_out;
    assign ch_done   = r_ch_done;
    assign fail_ch   = r_fail_ch;
    assign fail_code = r_fail_code;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_tohost_monitor.sv
// Scoreboard bench for tohost_monitor: expected end-of-run records are queued by the stimulus
// and popped by per-instance monitors whenever a run ends (busy falls).
module tb_tohost_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two 4-channel instances share data/mask/strobes; one single-channel instance.
    logic         start_a, start_b;
    logic [3:0]   mask4, we4;
    logic [127:0] wd4;
    logic         a_busy, a_done, a_pass, a_to;
    logic [3:0]   a_ch_done;
    logic [1:0]   a_fail_ch;
    logic [30:0]  a_fail_code;
    logic [31:0]  a_cycles;
    logic         b_busy, b_done, b_pass, b_to;
    logic [3:0]   b_ch_done;
    logic [1:0]   b_fail_ch;
    logic [30:0]  b_fail_code;
    logic [31:0]  b_cycles;

    logic         start_c, mask1, we1;
    logic [31:0]  wd1;
    logic         c_busy, c_done, c_pass, c_to;
    logic [0:0]   c_ch_done;
    logic [0:0]   c_fail_ch;
    logic [30:0]  c_fail_code;
    logic [31:0]  c_cycles;

    tohost_monitor #(.NUM_CH(4), .TIMEOUT_CYCLES(100), .STOP_ON_FAIL(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .ch_mask(mask4), .csr_we(we4), .csr_wdata(wd4),
        .busy(a_busy), .done(a_done), .pass(a_pass), .timed_out(a_to), .ch_done(a_ch_done),
        .fail_ch(a_fail_ch), .fail_code(a_fail_code), .cycles(a_cycles));

    tohost_monitor #(.NUM_CH(4), .TIMEOUT_CYCLES(100), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .ch_mask(mask4), .csr_we(we4), .csr_wdata(wd4),
        .busy(b_busy), .done(b_done), .pass(b_pass), .timed_out(b_to), .ch_done(b_ch_done),
        .fail_ch(b_fail_ch), .fail_code(b_fail_code), .cycles(b_cycles));

    tohost_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(100)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .ch_mask(mask1), .csr_we(we1), .csr_wdata(wd1),
        .busy(c_busy), .done(c_done), .pass(c_pass), .timed_out(c_to), .ch_done(c_ch_done),
        .fail_ch(c_fail_ch), .fail_code(c_fail_code), .cycles(c_cycles));

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        timed_out;
        logic [3:0]  ch_done;
        logic [1:0]  fail_ch;
        logic [30:0] fail_code;
        logic [31:0] cycles;
    } exp_t;

    exp_t  q_a[$], q_b[$], q_c[$];
    string n_a[$], n_b[$], n_c[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_end(input int sel, input string nm, input logic d, input logic p,
                              input logic t, input logic [3:0] cd, input logic [1:0] fc,
                              input logic [30:0] code, input logic [31:0] cy);
        exp_t e;
        e.done = d; e.pass = p; e.timed_out = t; e.ch_done = cd;
        e.fail_ch = fc; e.fail_code = code; e.cycles = cy;
        case (sel)
            0: begin q_a.push_back(e); n_a.push_back(nm); end
            1: begin q_b.push_back(e); n_b.push_back(nm); end
            default: begin q_c.push_back(e); n_c.push_back(nm); end
        endcase
    endtask

    task automatic compare_end(input string who, input string nm, input exp_t e,
                               input logic d, input logic p, input logic t, input logic [3:0] cd,
                               input logic [1:0] fc, input logic [30:0] code, input logic [31:0] cy);
        check({who, " ", nm, " done"},      64'(d),    64'(e.done));
        check({who, " ", nm, " pass"},      64'(p),    64'(e.pass));
        check({who, " ", nm, " timed_out"}, 64'(t),    64'(e.timed_out));
        check({who, " ", nm, " ch_done"},   64'(cd),   64'(e.ch_done));
        check({who, " ", nm, " fail_ch"},   64'(fc),   64'(e.fail_ch));
        check({who, " ", nm, " fail_code"}, 64'(code), 64'(e.fail_code));
        check({who, " ", nm, " cycles"},    64'(cy),   64'(e.cycles));
    endtask

    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

    always @(negedge clk) begin
        if (rst) pa = 1'b0;
        else begin
            if (pa && !a_busy) begin
                if (q_a.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL a unexpected end of run: no expected record queued");
                end else compare_end("a", n_a.pop_front(), q_a.pop_front(), a_done, a_pass, a_to,
                                     a_ch_done, a_fail_ch, a_fail_code, a_cycles);
            end
            pa = a_busy;
        end
    end

    always @(negedge clk) begin
        if (rst) pb = 1'b0;
        else begin
            if (pb && !b_busy) begin
                if (q_b.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL b unexpected end of run: no expected record queued");
                end else compare_end("b", n_b.pop_front(), q_b.pop_front(), b_done, b_pass, b_to,
                                     b_ch_done, b_fail_ch, b_fail_code, b_cycles);
            end
            pb = b_busy;
        end
    end

    always @(negedge clk) begin
        if (rst) pc = 1'b0;
        else begin
            if (pc && !c_busy) begin
                if (q_c.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL c unexpected end of run: no expected record queued");
                end else compare_end("c", n_c.pop_front(), q_c.pop_front(), c_done, c_pass, c_to,
                                     {3'b000, c_ch_done}, {1'b0, c_fail_ch}, c_fail_code, c_cycles);
            end
            pc = c_busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [31:0] d);
        we4[ch]          = 1'b1;
        wd4[ch*32 +: 32] = d;
    endtask

    task automatic clr4();
        we4 = '0;
        wd4 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mask4 = '0; we4 = '0; wd4 = '0;
        mask1 = 1'b1; we1 = 1'b0; wd1 = '0;
        tick(2);
        rst = 1'b0;
        tick(1);

        check("reset c busy", 64'(c_busy), 64'd0);
        check("reset c done", 64'(c_done), 64'd0);
        check("reset c cycles", 64'(c_cycles), 64'd0);
        check("reset a pass", 64'(a_pass), 64'd0);
        check("reset a timed_out", 64'(a_to), 64'd0);
        check("reset a ch_done", 64'(a_ch_done), 64'd0);

        // Single channel: pass after 50 run cycles.
        expect_end(2, "pass51", 1, 1, 0, 4'b0001, 2'd0, 31'd0, 32'd51);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        check("c busy after start", 64'(c_busy), 64'd1);
        check("c cycles after start", 64'(c_cycles), 64'd0);
        tick(1);
        check("c cycles one edge later", 64'(c_cycles), 64'd1);
        tick(49);
        we1 = 1'b1; wd1 = 32'h1; tick(1); we1 = 1'b0; wd1 = '0;
        tick(2);

        // Single channel: failing code 5, restarted from DONE.
        expect_end(2, "code5", 1, 0, 0, 4'b0001, 2'd0, 31'd5, 32'd4);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        tick(3);
        we1 = 1'b1; wd1 = 32'hB; tick(1); we1 = 1'b0; wd1 = '0;
        tick(2);

        // Timeout with no writes; fail fields must have been cleared by start.
        expect_end(2, "timeout", 0, 0, 1, 4'b0000, 2'd0, 31'd0, 32'd100);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        for (int k = 0; k < 150 && c_busy; k++) tick(1);
        check("c timeout reached within bound", 64'(c_busy), 64'd0);
        tick(2);

        // Completion on exactly the timeout cycle wins.
        expect_end(2, "done_at_100", 1, 1, 0, 4'b0001, 2'd0, 31'd0, 32'd100);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        tick(99);
        check("c cycles before last cycle", 64'(c_cycles), 64'd99);
        we1 = 1'b1; wd1 = 32'h1; tick(1); we1 = 1'b0; wd1 = '0;
        tick(2);

        // Four channels, mask 1011, shared stimulus into both STOP_ON_FAIL variants.
        expect_end(0, "mask1011", 1, 0, 0, 4'b1011, 2'd3, 31'd3, 32'd7);
        expect_end(1, "stop_on_fail", 1, 0, 0, 4'b1000, 2'd3, 31'd3, 32'd3);
        mask4 = 4'b1011;
        start_a = 1'b1; start_b = 1'b1; tick(1); start_a = 1'b0; start_b = 1'b0;
        mask4 = 4'b1111;
        tick(2);
        wr(3, 32'h7); tick(1); clr4();
        tick(1);
        wr(0, 32'h1); wr(2, 32'h3); tick(1); clr4();
        wr(1, 32'h2); wr(3, 32'h5); tick(1); clr4();
        check("a not done after progress write", 64'(a_done), 64'd0);
        check("a ch_done after progress write", 64'(a_ch_done), 64'b1001);
        wr(1, 32'h1); tick(1); clr4();
        tick(2);

        // Simultaneous completions; a lower-index failure replaces the earlier one.
        expect_end(0, "multi", 1, 0, 0, 4'b1111, 2'd1, 31'd1, 32'd3);
        mask4 = 4'b1111;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(1);
        wr(2, 32'h9); tick(1); clr4();
        check("a fail_ch after ch2 fail", 64'(a_fail_ch), 64'd2);
        wr(1, 32'h3); wr(0, 32'h1); wr(3, 32'hF); tick(1); clr4();
        tick(2);

        // All channels masked: one RUN cycle then pass.
        expect_end(0, "all_masked", 1, 1, 0, 4'b0000, 2'd0, 31'd0, 32'd1);
        mask4 = 4'b0000;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        check("a busy with all masked", 64'(a_busy), 64'd1);
        tick(3);

        // Mid-run asynchronous reset, checked before any further clock edge.
        start_c = 1'b1; tick(1); start_c = 1'b0;
        tick(10);
        #2 rst = 1'b1;
        #1;
        check("async rst c busy", 64'(c_busy), 64'd0);
        check("async rst c cycles", 64'(c_cycles), 64'd0);
        check("async rst c ch_done", 64'(c_ch_done), 64'd0);
        check("async rst a done", 64'(a_done), 64'd0);
        check("async rst a pass", 64'(a_pass), 64'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // start while busy is ignored.
        expect_end(2, "after_ignored_start", 1, 1, 0, 4'b0001, 2'd0, 31'd0, 32'd7);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        tick(5);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        check("c start while busy ignored", 64'(c_cycles), 64'd6);
        we1 = 1'b1; wd1 = 32'h1; tick(1); we1 = 1'b0; wd1 = '0;
        tick(1);

        // Restart from DONE fully clears and counts from 1.
        expect_end(2, "restart", 1, 0, 0, 4'b0001, 2'd0, 31'd5, 32'd2);
        start_c = 1'b1; tick(1); start_c = 1'b0;
        check("restart c done cleared", 64'(c_done), 64'd0);
        check("restart c pass cleared", 64'(c_pass), 64'd0);
        check("restart c ch_done cleared", 64'(c_ch_done), 64'd0);
        check("restart c cycles cleared", 64'(c_cycles), 64'd0);
        tick(1);
        check("restart c cycles counts from 1", 64'(c_cycles), 64'd1);
        we1 = 1'b1; wd1 = 32'hB; tick(1); we1 = 1'b0; wd1 = '0;
        tick(3);

        check("scoreboard a drained", 64'(q_a.size()), 64'd0);
        check("scoreboard b drained", 64'(q_b.size()), 64'd0);
        check("scoreboard c drained", 64'(q_c.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
